// File: rtl/io64_uart_tx_if.sv
// Bundle between the CPU output-port word and the UART serialiser: word in, line and status out.
interface io64_uart_tx_if;
  logic [15:0] IO64_OUT;
  logic        TX;
  logic        BUSY;
  logic        OVF;

  modport master (output IO64_OUT, input TX, BUSY, OVF);
  modport slave  (input IO64_OUT, output TX, BUSY, OVF);
endinterface

// File: rtl/io64_uart_tx.sv
// Queues every new IO64_OUT word and sends it as two UART bytes, low byte first, without stalling the CPU.
// Define IO64_UART_TX_PARITY_EN to append an even-parity bit to each byte.
module io64_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  io64_uart_tx_if.slave io
);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0]   FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef IO64_UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     prev;
  logic [15:0]     word;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     baud;
  logic [2:0]      bit_cnt;
  logic            hi;
  logic            ovf;
  logic            push_req, push_ok, pop, baud_done, tx_bit;
  logic [7:0]      cur_byte;

  assign push_req  = io.IO64_OUT != prev;
  assign pop       = (state == IDLE) && (count != '0);
  // A full queue still accepts a word on the cycle the FSM drains one.
  assign push_ok   = push_req && ((count < FULL) || pop);
  assign baud_done = baud == BAUD_LAST;
  assign cur_byte  = hi ? word[15:8] : word[7:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      prev <= io.IO64_OUT;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push_req && !push_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= io.IO64_OUT;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      baud    <= '0;
      bit_cnt <= '0;
      hi      <= 1'b0;
      word    <= '0;
    end else begin
      // Baud timer restarts on every state entry and at every bit boundary.
      if (state == IDLE || state_nx != state || baud_done) baud <= '0;
      else                                                 baud <= baud + 16'd1;
      if (pop) begin
        word    <= mem[rd_ptr];
        hi      <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (state == DATA && baud_done) bit_cnt <= bit_cnt + 3'd1;
        if (state == STOP && baud_done) hi      <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    tx_bit   = 1'b1;
    case (state)
      IDLE:  if (count != '0) state_nx = START;
      START: begin
        tx_bit = 1'b0;
        if (baud_done) state_nx = DATA;
      end
      DATA: begin
        tx_bit = cur_byte[bit_cnt];
`ifdef IO64_UART_TX_PARITY_EN
        if (baud_done && bit_cnt == 3'd7) state_nx = PARITY;
`else
        if (baud_done && bit_cnt == 3'd7) state_nx = STOP;
`endif
      end
`ifdef IO64_UART_TX_PARITY_EN
      PARITY: begin
        tx_bit = ^cur_byte;
        if (baud_done) state_nx = STOP;
      end
`endif
      STOP:    if (baud_done) state_nx = hi ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end

  assign io.TX   = tx_bit;
  assign io.BUSY = (state != IDLE) || (count != '0);
  assign io.OVF  = ovf;
endmodule
